// File: rtl/trans_phase_drive.sv
// Phase-shifted square-wave drive for an NCH-channel transducer array with a double-buffered phase table.
// Latency: trans and period_start are registered, one cycle after the base count they represent.
// No backpressure: writes are accepted or flagged every cycle, and a commit waits for the period boundary.
module trans_phase_drive #(
  parameter int PERIOD = 1250,
  parameter int DUTY   = 625,
  parameter int NCH    = 49
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           wr_en,
  input  logic [5:0]     wr_addr,
  input  logic [10:0]    wr_phase,
  input  logic           wr_ch_en,
  input  logic           commit,
  output logic           commit_pend,
  output logic           wr_err,
  output logic           period_start,
  output logic [NCH-1:0] trans
);

  localparam logic [10:0] LAST     = 11'(PERIOD - 1);
  localparam logic [11:0] PERIOD_W = 12'(PERIOD);
  localparam logic [11:0] DUTY_W   = 12'(DUTY);
  localparam logic [6:0]  NCH_W    = 7'(NCH);

  logic [10:0]    base_q, base_d;
  logic [10:0]    sh_phase_q  [NCH];
  logic [NCH-1:0] sh_en_q;
  logic [10:0]    act_phase_q [NCH];
  logic [NCH-1:0] act_en_q;
  logic           commit_pend_q, commit_pend_d;
  logic           wr_err_q;
  logic           period_start_q;
  logic [NCH-1:0] trans_q, trans_d;
  logic           wr_ok;
  logic           xfer;
  logic [11:0]    rel;

  // Next base count, write acceptance, and boundary transfer decision.
  always_comb begin
    base_d = (base_q == LAST) ? 11'd0 : base_q + 11'd1;
    wr_ok  = wr_en && ({1'b0, wr_addr} < NCH_W) && ({1'b0, wr_phase} < PERIOD_W);
    // A commit arriving in the last cycle still catches this boundary.
    xfer   = (base_q == LAST) && (commit_pend_q || commit);
    if (xfer) begin
      commit_pend_d = 1'b0;
    end else if (commit) begin
      commit_pend_d = 1'b1;
    end else begin
      commit_pend_d = commit_pend_q;
    end
  end

  // Per-channel position within its own shifted period, compared against the duty window.
  always_comb begin
    trans_d = '0;
    rel     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (base_q >= act_phase_q[i]) begin
        rel = {1'b0, base_q} - {1'b0, act_phase_q[i]};
      end else begin
        rel = {1'b0, base_q} + PERIOD_W - {1'b0, act_phase_q[i]};
      end
      trans_d[i] = act_en_q[i] && (rel < DUTY_W);
    end
  end

  // Base counter, commit bookkeeping and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      base_q         <= '0;
      commit_pend_q  <= 1'b0;
      wr_err_q       <= 1'b0;
      period_start_q <= 1'b0;
      trans_q        <= '0;
    end else begin
      base_q         <= base_d;
      commit_pend_q  <= commit_pend_d;
      wr_err_q       <= wr_en && !wr_ok;
      period_start_q <= (base_q == 11'd0);
      trans_q        <= trans_d;
    end
  end

  // Shadow table: host-side staging, written one entry per cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        sh_phase_q[i] <= '0;
      end
      sh_en_q <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_addr == 6'(i)) begin
          sh_phase_q[i] <= wr_phase;
          sh_en_q[i]    <= wr_ch_en;
        end
      end
    end
  end

  // Active table: only reloaded at the period boundary so waveforms are never cut short.
  // A same-cycle shadow write is not seen here because the copy uses the registered shadow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        act_phase_q[i] <= '0;
      end
      act_en_q <= '0;
    end else if (xfer) begin
      act_phase_q <= sh_phase_q;
      act_en_q    <= sh_en_q;
    end
  end

  assign commit_pend  = commit_pend_q;
  assign wr_err       = wr_err_q;
  assign period_start = period_start_q;
  assign trans        = trans_q;

endmodule

// File: tb/tb_trans_phase_drive.sv
// Directed bench for trans_phase_drive: stimulus queues expectations keyed by cycle number,
// a negedge monitor compares every expectation due in that cycle.
// Cycle co(k,b) is the cycle whose outputs reflect base b of period k after the first reset.
module tb_trans_phase_drive;

    localparam int P   = 1250;
    localparam int D   = 625;
    localparam int NCH = 49;
    localparam int T0  = 5;

    localparam int K_BIT   = 0;
    localparam int K_VEC   = 1;
    localparam int K_PS    = 2;
    localparam int K_PEND  = 3;
    localparam int K_ERR   = 4;
    localparam int K_SCHED = 5;

    logic           CLK;
    logic           RST;
    logic           wr_en;
    logic [5:0]     wr_addr;
    logic [10:0]    wr_phase;
    logic           wr_ch_en;
    logic           commit;
    logic           commit_pend;
    logic           wr_err;
    logic           period_start;
    logic [NCH-1:0] trans;

    trans_phase_drive #(.PERIOD(P), .DUTY(D), .NCH(NCH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_phase     (wr_phase),
        .wr_ch_en     (wr_ch_en),
        .commit       (commit),
        .commit_pend  (commit_pend),
        .wr_err       (wr_err),
        .period_start (period_start),
        .trans        (trans)
    );

    typedef struct {
        int             cyc;
        int             kind;
        int             idx;
        logic [NCH-1:0] val;
        string          name;
    } exp_t;

    exp_t           sb[$];
    int             cyc = 0;
    int             n_checks = 0;
    int             n_errs = 0;
    exp_t           e;
    logic [NCH-1:0] act;

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int co(input int k, input int b);
        return T0 + k * P + b;
    endfunction

    function automatic void expect_at(input int c, input int kind, input int idx,
                                      input longint v, input string nm);
        exp_t x;
        x.cyc  = c;
        x.kind = kind;
        x.idx  = idx;
        x.val  = NCH'(v);
        x.name = nm;
        sb.push_back(x);
    endfunction

    // Monitor: pop every expectation due this cycle (or overdue) and compare.
    always @(negedge CLK) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc <= cyc) begin
                e = sb[k];
                sb.delete(k);
                act = '0;
                case (e.kind)
                    K_BIT:   act[0] = trans[e.idx[5:0]];
                    K_VEC:   act = trans;
                    K_PS:    act[0] = period_start;
                    K_PEND:  act[0] = commit_pend;
                    K_ERR:   act[0] = wr_err;
                    default: act = '1;
                endcase
                n_checks++;
                if (e.cyc != cyc || act !== e.val) begin
                    n_errs++;
                    $display("FAIL %s at cycle %0d (due %0d): got %h expected %h",
                             e.name, cyc, e.cyc, act, e.val);
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        if (cyc > c) expect_at(cyc + 1, K_SCHED, 0, 0, "sched_late");
        while (cyc < c) @(negedge CLK);
    endtask

    // Present one cycle of inputs at the negedge of cycle c, sampled at edge c+1.
    task automatic pulse(input int c, input logic we, input logic [5:0] a,
                         input logic [10:0] ph, input logic en, input logic cm);
        wait_cyc(c);
        wr_en    = we;
        wr_addr  = a;
        wr_phase = ph;
        wr_ch_en = en;
        commit   = cm;
        @(negedge CLK);
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_phase = '0;
        wr_ch_en = 1'b0;
        commit   = 1'b0;
    endtask

    initial begin
        int t1;
        RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_phase = '0; wr_ch_en = 1'b0; commit = 1'b0;

        // Reset state; a write and commit during reset must be ignored.
        expect_at(3, K_VEC, 0, 0, "rst_trans");
        expect_at(3, K_PEND, 0, 0, "rst_pend");
        expect_at(3, K_ERR, 0, 0, "rst_err");
        expect_at(4, K_PS, 0, 0, "rst_ps");
        expect_at(T0, K_PS, 0, 1, "first_ps");
        expect_at(T0 + 1, K_PS, 0, 0, "first_ps_one_cycle");
        pulse(2, 1'b1, 6'd0, 11'd0, 1'b1, 1'b1);
        wait_cyc(4);
        RST = 1'b0;

        // Period 0: commit of an untouched shadow table leaves everything off.
        expect_at(co(0, 4), K_PEND, 0, 0, "pend_before");
        expect_at(co(0, 5), K_PEND, 0, 1, "pend_set");
        expect_at(co(0, P - 1), K_PEND, 0, 0, "pend_clr");
        expect_at(co(1, 0), K_VEC, 0, 0, "rst_wr_ignored_b0");
        expect_at(co(1, 600), K_VEC, 0, 0, "rst_wr_ignored_b600");
        pulse(co(0, 5) - 1, 1'b0, 6'd0, 11'd0, 1'b0, 1'b1);

        // Period 1: ch0 phase 0, applied at the start of period 2.
        expect_at(co(1, 1249), K_BIT, 0, 0, "ch0_not_early");
        expect_at(co(2, 0), K_VEC, 0, 1, "ch0_only");
        expect_at(co(2, 0), K_PS, 0, 1, "ps_p2");
        expect_at(co(2, 1), K_PS, 0, 0, "ps_p2_end");
        expect_at(co(2, 624), K_BIT, 0, 1, "ch0_last_high");
        expect_at(co(2, 625), K_BIT, 0, 0, "ch0_first_low");
        expect_at(co(2, 1249), K_BIT, 0, 0, "ch0_end_low");
        expect_at(co(2, 1100), K_BIT, 5, 0, "ch5_not_early");
        pulse(co(1, 100) - 1, 1'b1, 6'd0, 11'd0, 1'b1, 1'b0);
        pulse(co(1, 200) - 1, 1'b0, 6'd0, 11'd0, 1'b0, 1'b1);

        // Period 2: ch5 phase 1000, commit at base 10, repeat commit ignored.
        expect_at(co(2, 9), K_PEND, 0, 0, "pend_b9");
        expect_at(co(2, 10), K_PEND, 0, 1, "pend_b10");
        expect_at(co(2, 1248), K_PEND, 0, 1, "pend_b1248");
        expect_at(co(2, 1249), K_PEND, 0, 0, "pend_b1249");
        expect_at(co(3, 0), K_BIT, 0, 1, "ch0_p3");
        expect_at(co(3, 999), K_BIT, 5, 0, "ch5_b999");
        expect_at(co(3, 1000), K_BIT, 5, 1, "ch5_rise");
        expect_at(co(3, 1249), K_BIT, 5, 1, "ch5_b1249");
        expect_at(co(4, 0), K_BIT, 5, 1, "ch5_wrap");
        expect_at(co(4, 374), K_BIT, 5, 1, "ch5_last_high");
        expect_at(co(4, 375), K_BIT, 5, 0, "ch5_fall");
        pulse(co(2, 9) - 1, 1'b1, 6'd5, 11'd1000, 1'b1, 1'b0);
        pulse(co(2, 10) - 1, 1'b0, 6'd0, 11'd0, 1'b0, 1'b1);
        pulse(co(2, 500) - 1, 1'b0, 6'd0, 11'd0, 1'b0, 1'b1);

        // Period 3: rejected writes pulse wr_err and leave the table alone.
        expect_at(co(3, 19), K_ERR, 0, 0, "err_idle");
        expect_at(co(3, 20), K_ERR, 0, 1, "err_addr");
        expect_at(co(3, 21), K_ERR, 0, 0, "err_addr_end");
        expect_at(co(3, 22), K_ERR, 0, 1, "err_phase");
        expect_at(co(3, 23), K_ERR, 0, 0, "err_phase_end");
        expect_at(co(4, 100), K_VEC, 0, 'h21, "bad_wr_no_effect");
        pulse(co(3, 20) - 1, 1'b1, 6'd49, 11'd7, 1'b1, 1'b0);
        pulse(co(3, 22) - 1, 1'b1, 6'd3, 11'd1250, 1'b1, 1'b0);
        pulse(co(3, 30) - 1, 1'b0, 6'd0, 11'd0, 1'b0, 1'b1);

        // Periods 4-6: ch2 old value survives a same-cycle write at the transfer edge.
        expect_at(co(5, 0), K_BIT, 2, 1, "ch2_old_p5");
        expect_at(co(5, 1249), K_PEND, 0, 0, "late_commit_no_pend");
        expect_at(co(6, 0), K_PEND, 0, 0, "late_commit_done");
        expect_at(co(6, 100), K_BIT, 2, 1, "ch2_old_b100");
        expect_at(co(6, 700), K_BIT, 2, 0, "ch2_old_b700");
        expect_at(co(6, 5), K_PEND, 0, 1, "pend_p6");
        expect_at(co(7, 100), K_BIT, 2, 0, "ch2_new_b100");
        expect_at(co(7, 299), K_BIT, 2, 0, "ch2_new_b299");
        expect_at(co(7, 300), K_BIT, 2, 1, "ch2_new_rise");
        expect_at(co(7, 599), K_BIT, 2, 1, "ch2_new_b599");
        pulse(co(4, 50) - 1, 1'b1, 6'd2, 11'd0, 1'b1, 1'b0);
        pulse(co(4, 60) - 1, 1'b0, 6'd0, 11'd0, 1'b0, 1'b1);
        pulse(co(5, 1249) - 1, 1'b1, 6'd2, 11'd300, 1'b1, 1'b1);
        pulse(co(6, 5) - 1, 1'b0, 6'd0, 11'd0, 1'b0, 1'b1);

        // Period 7: reset mid-period with a commit pending.
        t1 = co(7, 600) + 1;
        expect_at(co(7, 599), K_PEND, 0, 1, "pend_before_rst");
        expect_at(co(7, 600), K_VEC, 0, 0, "rst_mid_trans");
        expect_at(co(7, 600), K_PEND, 0, 0, "rst_mid_pend");
        expect_at(co(7, 600), K_PS, 0, 0, "rst_mid_ps");
        expect_at(t1, K_PS, 0, 1, "ps_after_rst");
        expect_at(t1 + 1, K_PS, 0, 0, "ps_after_rst_end");
        expect_at(t1 + 3, K_PEND, 0, 0, "pend_discarded");
        expect_at(t1 + P, K_PS, 0, 1, "ps_next_period");
        expect_at(t1 + P, K_VEC, 0, 0, "trans_off_after_rst");
        pulse(co(7, 100) - 1, 1'b1, 6'd7, 11'd0, 1'b1, 1'b0);
        pulse(co(7, 110) - 1, 1'b0, 6'd0, 11'd0, 1'b0, 1'b1);
        wait_cyc(co(7, 600) - 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;

        wait_cyc(t1 + P + 3);
        @(negedge CLK);
        if (sb.size() != 0 || n_checks < 12) begin
            n_errs++;
            $display("FAIL scoreboard: %0d expectations never checked, %0d checks run",
                     sb.size(), n_checks);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/trans_phase_drive.md
TRANS_PHASE_DRIVE -- requirements
Module: trans_phase_drive

Interface
REQ-001 Parameter PERIOD, default 1250: base-cycle length in CLK cycles (50 MHz / 40 kHz).
REQ-002 Parameter DUTY, default 625: high cycles per period; legal range 1..PERIOD-1.
REQ-003 Parameter NCH, default 49: transducer channel count (7x7 array).
REQ-004 Port CLK  input  1  system clock, 50 MHz.
REQ-005 Port RST  input  1  reset; synchronous to CLK, active-high.
REQ-006 Port wr_en  input  1  shadow-table write strobe, one entry per cycle.
REQ-007 Port wr_addr  input  6  channel index 0..NCH-1.
REQ-008 Port wr_phase  input  11  phase delay in CLK cycles, 0..PERIOD-1.
REQ-009 Port wr_ch_en  input  1  channel enable bit written with the phase.
REQ-010 Port commit  input  1  request to copy the shadow table to the active table.
REQ-011 Port commit_pend  output  1  commit requested, transfer not yet done.
REQ-012 Port wr_err  output  1  one-cycle pulse flagging a rejected write.
REQ-013 Port period_start  output  1  one-cycle pulse aligned with the first output cycle of each period.
REQ-014 Port trans  output  NCH  drive signals; bit i drives transducer i+1.

Function
REQ-015 Base counter base SHALL count 0..PERIOD-1, increment every cycle, and wrap from PERIOD-1 to 0.
REQ-016 wr_en with wr_addr<NCH and wr_phase<PERIOD SHALL write {wr_ch_en, wr_phase} into shadow entry wr_addr on that clock edge.
REQ-017 wr_en with wr_addr>=NCH or wr_phase>=PERIOD SHALL leave the shadow table unchanged and SHALL pulse wr_err high for exactly the following cycle.
REQ-018 commit SHALL set commit_pend on the next edge; commit while commit_pend=1 SHALL have no further effect.
REQ-019 On the edge where base==PERIOD-1 and (commit_pend==1 or commit==1), the whole shadow table SHALL be copied to the active table and commit_pend SHALL be 0 after that edge.
REQ-020 A commit asserted in the base==PERIOD-1 cycle SHALL take effect at that boundary and SHALL leave commit_pend at 0.
REQ-021 A write in the transfer cycle SHALL update the shadow table only; the active table SHALL receive the pre-write shadow value.
REQ-022 The active table SHALL change only at period boundaries, so no channel waveform is ever truncated mid-period.
REQ-023 Per channel, rel SHALL be base-phase when base>=phase, else base+PERIOD-phase, computed in 12 bits without overflow.
REQ-024 trans[i] SHALL be registered: trans[i] <= act_en[i] AND (rel_i < DUTY), giving a latency of 1 cycle from base.
REQ-025 A channel with act_en=0 SHALL hold trans[i]=0 continuously.
REQ-026 Phase 0 SHALL give high during output cycles for base 0..DUTY-1; phase p SHALL delay the waveform by exactly p cycles, wrapping across the period boundary.
REQ-027 period_start SHALL be registered high in the cycle whose trans values correspond to base==0.

Reset
REQ-028 While RST=1 on an edge: base=0; all shadow and active phases=0 and enables=0; trans=0; commit_pend=0; wr_err=0; period_start=0.
REQ-029 RST SHALL override writes and commit in the same cycle.
REQ-030 RST mid-period SHALL discard any pending commit.
REQ-031 The first cycle with RST=0 SHALL evaluate base=0, so period_start pulses on the second cycle after RST deasserts.

Verification
REQ-032 Reset, write ch0 phase0 en=1, commit -> after the boundary, trans[0] is high 625 cycles and low 625 cycles, period 1250; all other bits are 0.
REQ-033 Write ch5 phase=1000 en=1, commit -> trans[5] rises 1000 cycles after period_start, stays high through the wrap, 625 cycles total per period.
REQ-034 Commit at base=10 -> commit_pend=1 for 1239 cycles; the new table is applied at the next period_start; a second commit during pending is ignored.
REQ-035 Write addr=49, then addr=3 with phase=1250 -> wr_err pulses for one cycle each; a shadow read-back via a later commit shows both entries unchanged.
REQ-036 Commit and a write to ch2 both in the base=1249 cycle -> the active table holds ch2's old value; a subsequent commit applies the new one.
REQ-037 Assert RST at base=600 with commit_pend=1 -> all trans are 0 and commit_pend is 0 the next cycle; period_start follows 2 cycles after release.
